bp_writeback_scheduler: RTL and testbench
=========================================

# bp_writeback_scheduler

Sequences a complete BP-buffer-to-DDR writeback job over the BP write controller. Each job is a series of passes. For every pass the block computes the DDR and BP addresses, pulses a single-cycle configuration into the write controller, waits for that controller to finish, and waits for the DDR writer to confirm that the burst has landed. It sits between the layer-level control FSM and the BP write controller, and replaces per-pass sequencing in software.

## Interface
- DDR_ADDR_LEN, 32, DDR byte address width
- ADDR_LEN, 16, BP buffer word address width
- SINGLE_LEN, 24, length, count and line-width field width
- Reset: rst_n, synchronous, active-low. Clock: clk.
- clk  in  1  clock
- rst_n  in  1  synchronous active-low reset
- start  in  1  one-cycle job start; sampled only in IDLE
- abort  in  1  level; stop after the current pass completes
- job_ddr_base  in  DDR_ADDR_LEN  DDR byte address of pass 0
- job_ddr_stride  in  DDR_ADDR_LEN  DDR byte increment per pass
- job_bp_base  in  ADDR_LEN  BP word address of passes 0/1
- job_bp_stride  in  ADDR_LEN  BP address increment per pass pair
- job_pass_num  in  SINGLE_LEN  number of passes
- job_line_width  in  SINGLE_LEN  BP words per MAC line
- wc_conf  out  1  one-cycle configure pulse to the write controller
- wc_ddr_st_addr  out  DDR_ADDR_LEN  DDR address for the pass
- wc_data_ddr_byte  out  SINGLE_LEN  byte count for the pass
- wc_bp_st_addr  out  ADDR_LEN  BP start address
- wc_bp_st_num  out  2  first MAC group of the pass (0 or 2)
- wc_line_width  out  SINGLE_LEN  line width
- wc_idle  in  1  write controller idle
- ddr_wr_done  in  1  one-cycle pulse: the DDR writer completed one configured burst
- busy  out  1  job in progress
- done  out  1  one-cycle pulse at job end
- err  out  1  sticky until next start: job rejected (line_width == 0)

## Operation
- States: IDLE, ISSUE, WAIT_ACK, WAIT_IDLE, WAIT_DDR, NEXT, FINISH.
- IDLE, start=1:
  - Latch all job fields.
  - Pass counter p = 0.
  - DDR accumulator = job_ddr_base; BP accumulator = job_bp_base.
  - Clear err and the sticky done flag.
  - If pass_num == 0: go to FINISH.
  - If line_width == 0: set err, go to FINISH.
  - Otherwise go to ISSUE.
- ISSUE:
  - Drive wc_conf=1 for exactly one cycle.
  - Drive wc_ddr_st_addr = DDR accumulator, wc_bp_st_addr = BP accumulator.
  - Drive wc_bp_st_num = {p[0],1'b0}, wc_line_width = line_width.
  - Drive wc_data_ddr_byte = line_width<<7, truncated to SINGLE_LEN (2 lines × 64 B per word).
  - Go to WAIT_ACK.
- WAIT_ACK: wait for wc_idle=0, which confirms the controller accepted the pass, then go to WAIT_IDLE.
- WAIT_IDLE: wait for wc_idle=1, then go to WAIT_DDR.
- WAIT_DDR: wait until the sticky done flag is set, then clear it and go to NEXT.
  - The sticky flag is set by any ddr_wr_done pulse seen after wc_conf, so an early pulse is not lost.
- NEXT:
  - p += 1; DDR accumulator += ddr_stride (modulo 2^DDR_ADDR_LEN).
  - If the old p[0] == 1: BP accumulator += bp_stride (modulo 2^ADDR_LEN).
  - If p == pass_num or abort == 1: go to FINISH. Otherwise go to ISSUE.
- FINISH: done=1 for one cycle, then go to IDLE.
- Address arithmetic uses running accumulators only; the block contains no multipliers.
- Boundary behaviour:
  - start outside IDLE is ignored.
  - abort in IDLE has no effect.
  - abort never truncates a pass that has already been issued.
  - A second ddr_wr_done arriving while the sticky flag is still set is dropped. The protocol guarantees one pulse per conf.
- Reset mid-job: state returns to IDLE, all outputs go to their reset values, and latched fields are cleared. The downstream controller is reset separately by the same rst_n.

## Timing
- Reset values:
  - wc_conf = 0, busy = 0, done = 0, err = 0.
  - wc_ddr_st_addr, wc_data_ddr_byte, wc_bp_st_addr, wc_bp_st_num, wc_line_width all = 0.
- All outputs are registered.
- busy rises in the cycle after start is sampled. It falls in the same cycle that done pulses.
- wc_conf rises 1 cycle after start (2 cycles if a NEXT state precedes it).
- The wc_* data fields are stable from the wc_conf cycle until the next ISSUE.
- Minimum gap between consecutive wc_conf pulses: 5 cycles, given instant acknowledgement and completion.
- done for pass_num == 0 occurs 2 cycles after start.

## Structure
- Shared package:
  - State enum.
  - Constant BYTES_PER_WORD_LOG2 = 6.
  - Constant LINES_PER_PASS = 2.
  - Job-descriptor field widths.
- One natural sub-module, bp_wb_addr_gen: the DDR and BP accumulators plus the pass counter, with init, step and last outputs.
- The FSM lives in the top-level module.

## Test plan
- pass_num=4, ddr_base=0x1000, ddr_stride=0x800, bp_base=0x10, bp_stride=0x20, line_width=8:
  - 4 wc_conf pulses.
  - DDR addresses 0x1000, 0x1800, 0x2000, 0x2800.
  - BP addresses 0x10, 0x10, 0x30, 0x30; st_num 0, 2, 0, 2.
  - data_ddr_byte = 1024 on every pass; one done pulse.
- pass_num=0 -> no wc_conf, done 2 cycles after start, err=0.
- line_width=0 -> no wc_conf, err=1, done pulse.
- ddr_wr_done pulsed during WAIT_IDLE (early) -> sticky flag captured; the next pass issues without a hang.
- abort asserted during pass 1 of 4 -> exactly 2 wc_conf pulses, then done.
- rst_n low during WAIT_IDLE, then start with pass_num=1 -> all outputs at reset values; the new job issues from the new base.

Source files
------------

// File: rtl/bp_writeback_scheduler_pkg.sv
// Shared types and constants for the BP-to-DDR writeback scheduler.
// Job field widths, FSM state encoding and pass byte-count helper.
package bp_writeback_scheduler_pkg;

   localparam int DDR_ADDR_LEN = 32;
   localparam int ADDR_LEN = 16;
   localparam int SINGLE_LEN = 24;

   localparam int BYTES_PER_WORD_LOG2 = 6;
   localparam int LINES_PER_PASS = 2;
   localparam int PASS_SHIFT =
      BYTES_PER_WORD_LOG2 + $clog2(LINES_PER_PASS);

   typedef enum logic [2:0] {
      S_IDLE,
      S_ISSUE,
      S_WAIT_ACK,
      S_WAIT_IDLE,
      S_WAIT_DDR,
      S_NEXT,
      S_FINISH
   } state_t;

   // Two MAC lines of 64-byte words per pass; wraps at SINGLE_LEN.
   function automatic logic [SINGLE_LEN-1:0] pass_bytes(
      input logic [SINGLE_LEN-1:0] lw
   );
      return lw << PASS_SHIFT;
   endfunction

endpackage

// File: rtl/bp_writeback_scheduler_if.sv
// Scheduler <-> BP write controller / DDR writer handshake bundle.
// master = scheduler side, slave = controller side.
interface bp_writeback_scheduler_if;
   import bp_writeback_scheduler_pkg::*;

   logic                    wc_conf;
   logic [DDR_ADDR_LEN-1:0] wc_ddr_st_addr;
   logic [SINGLE_LEN-1:0]   wc_data_ddr_byte;
   logic [ADDR_LEN-1:0]     wc_bp_st_addr;
   logic [1:0]              wc_bp_st_num;
   logic [SINGLE_LEN-1:0]   wc_line_width;
   logic                    wc_idle;
   logic                    ddr_wr_done;

   modport master (
      output wc_conf,
      output wc_ddr_st_addr,
      output wc_data_ddr_byte,
      output wc_bp_st_addr,
      output wc_bp_st_num,
      output wc_line_width,
      input  wc_idle,
      input  ddr_wr_done
   );

   modport slave (
      input  wc_conf,
      input  wc_ddr_st_addr,
      input  wc_data_ddr_byte,
      input  wc_bp_st_addr,
      input  wc_bp_st_num,
      input  wc_line_width,
      output wc_idle,
      output ddr_wr_done
   );

endinterface

// File: rtl/bp_wb_addr_gen.sv
// Running DDR/BP address accumulators and pass counter.
// BP address advances once per pass pair (after odd passes).
module bp_wb_addr_gen
   import bp_writeback_scheduler_pkg::*;
(
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    i_init,
   input  logic                    i_step,
   input  logic [DDR_ADDR_LEN-1:0] i_ddr_base,
   input  logic [DDR_ADDR_LEN-1:0] i_ddr_stride,
   input  logic [ADDR_LEN-1:0]     i_bp_base,
   input  logic [ADDR_LEN-1:0]     i_bp_stride,
   input  logic [SINGLE_LEN-1:0]   i_pass_num,
   output logic [DDR_ADDR_LEN-1:0] o_ddr_addr,
   output logic [ADDR_LEN-1:0]     o_bp_addr,
   output logic                    o_pass_odd,
   output logic                    o_last
);

   logic [DDR_ADDR_LEN-1:0] r_ddr_acc;
   logic [DDR_ADDR_LEN-1:0] r_ddr_stride;
   logic [ADDR_LEN-1:0]     r_bp_acc;
   logic [ADDR_LEN-1:0]     r_bp_stride;
   logic [SINGLE_LEN-1:0]   r_pass;
   logic [SINGLE_LEN-1:0]   r_pass_num;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_ddr_acc    <= '0;
         r_ddr_stride <= '0;
         r_bp_acc     <= '0;
         r_bp_stride  <= '0;
         r_pass       <= '0;
         r_pass_num   <= '0;
      end else if (i_init) begin
         r_ddr_acc    <= i_ddr_base;
         r_ddr_stride <= i_ddr_stride;
         r_bp_acc     <= i_bp_base;
         r_bp_stride  <= i_bp_stride;
         r_pass       <= '0;
         r_pass_num   <= i_pass_num;
      end else if (i_step) begin
         r_pass    <= r_pass + SINGLE_LEN'(1);
         r_ddr_acc <= r_ddr_acc + r_ddr_stride;
         if (r_pass[0])
            r_bp_acc <= r_bp_acc + r_bp_stride;
      end
   end

   assign o_ddr_addr = r_ddr_acc;
   assign o_bp_addr  = r_bp_acc;
   assign o_pass_odd = r_pass[0];
   assign o_last     = (r_pass == r_pass_num);

endmodule

// File: rtl/bp_writeback_scheduler.sv
// Per-pass sequencer for a BP-buffer-to-DDR writeback job.
// Issues one controller config per pass and waits for DDR completion.
module bp_writeback_scheduler
   import bp_writeback_scheduler_pkg::*;
(
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    i_start,
   input  logic                    i_abort,
   input  logic [DDR_ADDR_LEN-1:0] i_job_ddr_base,
   input  logic [DDR_ADDR_LEN-1:0] i_job_ddr_stride,
   input  logic [ADDR_LEN-1:0]     i_job_bp_base,
   input  logic [ADDR_LEN-1:0]     i_job_bp_stride,
   input  logic [SINGLE_LEN-1:0]   i_job_pass_num,
   input  logic [SINGLE_LEN-1:0]   i_job_line_width,
   bp_writeback_scheduler_if.master wc,
   output logic                    o_busy,
   output logic                    o_done,
   output logic                    o_err
);

   state_t                  r_state;
   logic [SINGLE_LEN-1:0]   r_line_width;
   logic                    r_ddr_seen;
   logic                    r_conf;
   logic [DDR_ADDR_LEN-1:0] r_ddr_addr;
   logic [SINGLE_LEN-1:0]   r_bytes;
   logic [ADDR_LEN-1:0]     r_bp_addr;
   logic [1:0]              r_st_num;
   logic [SINGLE_LEN-1:0]   r_lw_out;
   logic                    r_busy;
   logic                    r_done;
   logic                    r_err;

   logic                    w_init;
   logic                    w_step;
   logic [DDR_ADDR_LEN-1:0] w_ddr_addr;
   logic [ADDR_LEN-1:0]     w_bp_addr;
   logic                    w_pass_odd;
   logic                    w_last;
   logic                    w_in_pass;

   assign w_init = (r_state == S_IDLE) && i_start;
   assign w_step = (r_state == S_WAIT_DDR) && r_ddr_seen;
   assign w_in_pass = (r_state == S_WAIT_ACK) ||
                      (r_state == S_WAIT_IDLE) ||
                      (r_state == S_WAIT_DDR);

   bp_wb_addr_gen u_addr_gen (
      .clk          (clk),
      .rst_n        (rst_n),
      .i_init       (w_init),
      .i_step       (w_step),
      .i_ddr_base   (i_job_ddr_base),
      .i_ddr_stride (i_job_ddr_stride),
      .i_bp_base    (i_job_bp_base),
      .i_bp_stride  (i_job_bp_stride),
      .i_pass_num   (i_job_pass_num),
      .o_ddr_addr   (w_ddr_addr),
      .o_bp_addr    (w_bp_addr),
      .o_pass_odd   (w_pass_odd),
      .o_last       (w_last)
   );

   // Accumulators step on leaving WAIT_DDR, so NEXT already sees p+1.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_state      <= S_IDLE;
         r_line_width <= '0;
         r_ddr_seen   <= 1'b0;
         r_conf       <= 1'b0;
         r_ddr_addr   <= '0;
         r_bytes      <= '0;
         r_bp_addr    <= '0;
         r_st_num     <= '0;
         r_lw_out     <= '0;
         r_busy       <= 1'b0;
         r_done       <= 1'b0;
         r_err        <= 1'b0;
      end else begin
         r_conf <= 1'b0;
         r_done <= 1'b0;
         if (w_in_pass && wc.ddr_wr_done)
            r_ddr_seen <= 1'b1;
         unique case (r_state)
            S_IDLE: begin
               if (i_start) begin
                  r_line_width <= i_job_line_width;
                  r_ddr_seen   <= 1'b0;
                  r_err        <= 1'b0;
                  r_busy       <= 1'b1;
                  if (i_job_pass_num == '0) begin
                     r_state <= S_FINISH;
                  end else if (i_job_line_width == '0) begin
                     r_err   <= 1'b1;
                     r_state <= S_FINISH;
                  end else begin
                     r_conf     <= 1'b1;
                     r_ddr_addr <= i_job_ddr_base;
                     r_bp_addr  <= i_job_bp_base;
                     r_st_num   <= 2'b00;
                     r_lw_out   <= i_job_line_width;
                     r_bytes    <= pass_bytes(i_job_line_width);
                     r_state    <= S_ISSUE;
                  end
               end
            end
            S_ISSUE: r_state <= S_WAIT_ACK;
            S_WAIT_ACK: begin
               if (!wc.wc_idle)
                  r_state <= S_WAIT_IDLE;
            end
            S_WAIT_IDLE: begin
               if (wc.wc_idle)
                  r_state <= S_WAIT_DDR;
            end
            S_WAIT_DDR: begin
               if (r_ddr_seen) begin
                  r_ddr_seen <= 1'b0;
                  r_state    <= S_NEXT;
               end
            end
            S_NEXT: begin
               if (w_last || i_abort) begin
                  r_state <= S_FINISH;
               end else begin
                  r_conf     <= 1'b1;
                  r_ddr_addr <= w_ddr_addr;
                  r_bp_addr  <= w_bp_addr;
                  r_st_num   <= {w_pass_odd, 1'b0};
                  r_lw_out   <= r_line_width;
                  r_bytes    <= pass_bytes(r_line_width);
                  r_state    <= S_ISSUE;
               end
            end
            S_FINISH: begin
               r_done  <= 1'b1;
               r_busy  <= 1'b0;
               r_state <= S_IDLE;
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   assign wc.wc_conf          = r_conf;
   assign wc.wc_ddr_st_addr   = r_ddr_addr;
   assign wc.wc_data_ddr_byte = r_bytes;
   assign wc.wc_bp_st_addr    = r_bp_addr;
   assign wc.wc_bp_st_num     = r_st_num;
   assign wc.wc_line_width    = r_lw_out;
   assign o_busy = r_busy;
   assign o_done = r_done;
   assign o_err  = r_err;

endmodule

// File: tb/tb_bp_writeback_scheduler.sv
// Scoreboard bench for bp_writeback_scheduler with a controller model.
// Expected configs/done events are queued; monitors pop and compare.
module tb_bp_writeback_scheduler;
   import bp_writeback_scheduler_pkg::*;

   typedef struct {
      logic [31:0] ddr;
      logic [23:0] bytes;
      logic [15:0] bp;
      logic [1:0]  st;
      logic [23:0] lw;
   } conf_t;

   logic        clk;
   logic        rst_n;
   logic        start;
   logic        abort;
   logic [31:0] ddr_base;
   logic [31:0] ddr_stride;
   logic [15:0] bp_base;
   logic [15:0] bp_stride;
   logic [23:0] pass_num;
   logic [23:0] line_width;
   logic        busy;
   logic        done;
   logic        err;

   int total = 0;
   int bad = 0;
   int n_conf = 0;
   bit early_mode = 0;
   bit hold_mode = 0;
   conf_t cq[$];
   logic  dq[$];

   bp_writeback_scheduler_if ifc ();

   bp_writeback_scheduler dut (
      .clk              (clk),
      .rst_n            (rst_n),
      .i_start          (start),
      .i_abort          (abort),
      .i_job_ddr_base   (ddr_base),
      .i_job_ddr_stride (ddr_stride),
      .i_job_bp_base    (bp_base),
      .i_job_bp_stride  (bp_stride),
      .i_job_pass_num   (pass_num),
      .i_job_line_width (line_width),
      .wc               (ifc.master),
      .o_busy           (busy),
      .o_done           (done),
      .o_err            (err)
   );

   initial clk = 0;
   always #5 clk = ~clk;

   task automatic chk(input string nm,
                      input logic [31:0] act,
                      input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h want %h", nm, act, exp);
      end
   endtask

   task automatic push(input logic [31:0] d, input logic [23:0] b,
                       input logic [15:0] p, input logic [1:0] s,
                       input logic [23:0] l);
      conf_t c;
      c.ddr = d; c.bytes = b; c.bp = p; c.st = s; c.lw = l;
      cq.push_back(c);
   endtask

   task automatic run_job(input logic [31:0] db, input logic [31:0] ds,
                          input logic [15:0] bb, input logic [15:0] bs,
                          input logic [23:0] pn, input logic [23:0] lw);
      @(posedge clk);
      #1;
      ddr_base = db; ddr_stride = ds;
      bp_base = bb; bp_stride = bs;
      pass_num = pn; line_width = lw;
      n_conf = 0;
      start = 1;
      @(posedge clk);
      #1 start = 0;
   endtask

   task automatic wait_conf(input int k);
      for (int i = 0; i < 300 && n_conf < k; i++) @(negedge clk);
      chk("conf_wait", n_conf, k);
   endtask

   task automatic wait_done(input string nm, input int k);
      int i;
      for (i = 0; i < 500 && !done; i++) @(negedge clk);
      chk({nm, "_done_seen"}, {31'd0, done}, 32'd1);
      @(negedge clk);
      chk({nm, "_nconf"}, n_conf, k);
      chk({nm, "_cq_empty"}, cq.size(), 0);
   endtask

   // Conf monitor
   initial begin
      conf_t e;
      forever begin
         @(negedge clk);
         if (ifc.wc_conf === 1'b1) begin
            n_conf++;
            if (cq.size() == 0) begin
               chk("conf_unexpected", 1, 0);
            end else begin
               e = cq.pop_front();
               chk("ddr_addr", ifc.wc_ddr_st_addr, e.ddr);
               chk("ddr_byte", {8'd0, ifc.wc_data_ddr_byte}, {8'd0, e.bytes});
               chk("bp_addr", {16'd0, ifc.wc_bp_st_addr}, {16'd0, e.bp});
               chk("st_num", {30'd0, ifc.wc_bp_st_num}, {30'd0, e.st});
               chk("line_w", {8'd0, ifc.wc_line_width}, {8'd0, e.lw});
            end
         end
      end
   end

   // Done monitor
   initial begin
      logic ee;
      forever begin
         @(negedge clk);
         if (done === 1'b1) begin
            if (dq.size() == 0) begin
               chk("done_unexpected", 1, 0);
            end else begin
               ee = dq.pop_front();
               chk("done_err", {31'd0, err}, {31'd0, ee});
               chk("done_busy", {31'd0, busy}, 32'd0);
            end
         end
      end
   end

   // Write controller + DDR writer model
   initial begin
      ifc.wc_idle = 1;
      ifc.ddr_wr_done = 0;
      forever begin
         @(negedge clk);
         if (ifc.wc_conf === 1'b1) begin
            @(posedge clk);
            #1 ifc.wc_idle = 0;
            if (hold_mode) begin
               for (int i = 0; i < 300; i++) begin
                  if (!rst_n) break;
                  @(posedge clk);
               end
               #1 ifc.wc_idle = 1;
            end else begin
               if (early_mode) begin
                  @(posedge clk);
                  #1 ifc.ddr_wr_done = 1;
                  @(posedge clk);
                  #1 ifc.ddr_wr_done = 0;
               end
               repeat (2) @(posedge clk);
               #1 ifc.wc_idle = 1;
               if (!early_mode) begin
                  repeat (2) @(posedge clk);
                  #1 ifc.ddr_wr_done = 1;
                  @(posedge clk);
                  #1 ifc.ddr_wr_done = 0;
               end
            end
         end
      end
   end

   initial begin
      rst_n = 0; start = 0; abort = 0;
      ddr_base = 0; ddr_stride = 0;
      bp_base = 0; bp_stride = 0;
      pass_num = 0; line_width = 0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("rst_conf", {31'd0, ifc.wc_conf}, 0);
      chk("rst_busy", {31'd0, busy}, 0);
      chk("rst_done", {31'd0, done}, 0);
      chk("rst_err", {31'd0, err}, 0);
      chk("rst_ddr", ifc.wc_ddr_st_addr, 0);
      chk("rst_bp", {16'd0, ifc.wc_bp_st_addr}, 0);
      @(posedge clk);
      #1 rst_n = 1;

      // Four-pass job; a stray start mid-job must be ignored
      push(32'h1000, 24'd1024, 16'h10, 2'd0, 24'd8);
      push(32'h1800, 24'd1024, 16'h10, 2'd2, 24'd8);
      push(32'h2000, 24'd1024, 16'h30, 2'd0, 24'd8);
      push(32'h2800, 24'd1024, 16'h30, 2'd2, 24'd8);
      dq.push_back(1'b0);
      run_job(32'h1000, 32'h800, 16'h10, 16'h20, 24'd4, 24'd8);
      @(negedge clk);
      chk("t1_conf_lat", {31'd0, ifc.wc_conf}, 1);
      chk("t1_busy", {31'd0, busy}, 1);
      repeat (3) @(posedge clk);
      #1 start = 1; pass_num = 0;
      @(posedge clk);
      #1 start = 0;
      wait_done("t1", 4);

      // Zero passes: done two cycles after start
      dq.push_back(1'b0);
      run_job(32'h0, 32'h0, 16'h0, 16'h0, 24'd0, 24'd5);
      @(negedge clk);
      chk("t2_busy1", {31'd0, busy}, 1);
      chk("t2_done1", {31'd0, done}, 0);
      @(negedge clk);
      chk("t2_done2", {31'd0, done}, 1);
      chk("t2_err", {31'd0, err}, 0);
      repeat (3) @(negedge clk);
      chk("t2_nconf", n_conf, 0);

      // Zero line width: rejected, err sticky
      dq.push_back(1'b1);
      run_job(32'h0, 32'h40, 16'h0, 16'h1, 24'd3, 24'd0);
      wait_done("t3", 0);
      repeat (4) @(negedge clk);
      chk("t3_err_sticky", {31'd0, err}, 1);

      // Early DDR completion while controller still busy
      early_mode = 1;
      push(32'h100, 24'd384, 16'h5, 2'd0, 24'd3);
      push(32'h140, 24'd384, 16'h5, 2'd2, 24'd3);
      dq.push_back(1'b0);
      run_job(32'h100, 32'h40, 16'h5, 16'h3, 24'd2, 24'd3);
      @(negedge clk);
      chk("t4_err_clr", {31'd0, err}, 0);
      wait_done("t4", 2);
      early_mode = 0;

      // Abort during pass 1 of 4
      push(32'h0, 24'd128, 16'h0, 2'd0, 24'd1);
      push(32'h100, 24'd128, 16'h0, 2'd2, 24'd1);
      dq.push_back(1'b0);
      run_job(32'h0, 32'h100, 16'h0, 16'h1, 24'd4, 24'd1);
      wait_conf(2);
      #1 abort = 1;
      wait_done("t5", 2);
      abort = 0;

      // Address and byte-count wraparound
      push(32'hFFFFFF00, 24'h80, 16'hFFF0, 2'd0, 24'h20001);
      push(32'h00000000, 24'h80, 16'hFFF0, 2'd2, 24'h20001);
      push(32'h00000100, 24'h80, 16'h0010, 2'd0, 24'h20001);
      dq.push_back(1'b0);
      run_job(32'hFFFFFF00, 32'h100, 16'hFFF0, 16'h20,
              24'd3, 24'h20001);
      wait_done("t6", 3);

      // Reset mid-job, then fresh single-pass job
      hold_mode = 1;
      push(32'hAAAA0000, 24'd1024, 16'h200, 2'd0, 24'd8);
      run_job(32'hAAAA0000, 32'h10, 16'h200, 16'h4, 24'd3, 24'd8);
      wait_conf(1);
      repeat (3) @(posedge clk);
      #1 rst_n = 0;
      @(posedge clk);
      @(negedge clk);
      chk("mr_busy", {31'd0, busy}, 0);
      chk("mr_conf", {31'd0, ifc.wc_conf}, 0);
      chk("mr_ddr", ifc.wc_ddr_st_addr, 0);
      chk("mr_bytes", {8'd0, ifc.wc_data_ddr_byte}, 0);
      chk("mr_bp", {16'd0, ifc.wc_bp_st_addr}, 0);
      chk("mr_st", {30'd0, ifc.wc_bp_st_num}, 0);
      chk("mr_lw", {8'd0, ifc.wc_line_width}, 0);
      @(posedge clk);
      #1 rst_n = 1;
      hold_mode = 0;
      push(32'h4000, 24'd4096, 16'h77, 2'd0, 24'h20);
      dq.push_back(1'b0);
      run_job(32'h4000, 32'h10, 16'h77, 16'h4, 24'd1, 24'h20);
      wait_done("t7", 1);
      chk("dq_empty", dq.size(), 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
